// File: rtl/pipe_skid_stage_if.sv
// Valid/ready/data handshake bundle for one pipeline boundary.
// The producer side uses modport master, the consumer side uses modport slave.
interface pipe_skid_stage_if #(
    parameter int unsigned WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Reusable pipeline-stage register with valid/ready handshake, flush-to-bubble,
// optional skid entry (registered in_ready) and a saturating backpressure counter.
module pipe_skid_stage #(
    parameter int unsigned      WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 flush,
    pipe_skid_stage_if.slave     up,
    pipe_skid_stage_if.master    dn,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               main_v_q, main_v_d;
    logic [WIDTH-1:0]   main_d_q, main_d_d;
    logic               skid_v_q, skid_v_d;
    logic [WIDTH-1:0]   skid_d_q, skid_d_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic               in_ready_c;
    logic               accept_c;
    logic               drain_c;

    // Registered ready with a skid entry; pass-through ready otherwise.
    generate
        if (SKID) begin : g_ready_skid
            assign in_ready_c = ~skid_v_q;
        end else begin : g_ready_pass
            assign in_ready_c = ~main_v_q | dn.ready;
        end
    endgenerate

    assign accept_c = up.valid & in_ready_c;
    assign drain_c  = main_v_q & dn.ready;

    assign up.ready  = in_ready_c;
    assign dn.valid  = main_v_q;
    assign dn.data   = main_d_q;
    assign occupancy = 2'(state_q);
    assign stall_cnt = stall_cnt_q;

    // Next-state and datapath; flush overrides every transfer.
    always_comb begin
        state_d  = state_q;
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            state_d  = EMPTY;
            main_v_d = 1'b0;
            main_d_d = BUBBLE;
            skid_v_d = 1'b0;
            skid_d_d = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        state_d  = ONE;
                        main_v_d = 1'b1;
                        main_d_d = up.data;
                    end
                end
                ONE: begin
                    if (drain_c && accept_c) begin
                        main_d_d = up.data;
                    end else if (drain_c) begin
                        state_d  = EMPTY;
                        main_v_d = 1'b0;
                        main_d_d = BUBBLE;
                    end else if (accept_c && SKID) begin
                        state_d  = TWO;
                        skid_v_d = 1'b1;
                        skid_d_d = up.data;
                    end
                end
                TWO: begin
                    // The skid entry is older than any new input, so it moves up first.
                    if (drain_c) begin
                        state_d  = ONE;
                        main_d_d = skid_d_q;
                        skid_v_d = 1'b0;
                        skid_d_d = BUBBLE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_v_d = 1'b0;
                    main_d_d = BUBBLE;
                    skid_v_d = 1'b0;
                    skid_d_d = BUBBLE;
                end
            endcase
        end
    end

    // Stage storage.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= EMPTY;
            main_v_q <= 1'b0;
            main_d_q <= BUBBLE;
            skid_v_q <= 1'b0;
            skid_d_q <= BUBBLE;
        end else begin
            state_q  <= state_d;
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end

    // Saturating count of cycles where a live payload is held back; flush does not touch it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stall_cnt_q <= '0;
        end else if (main_v_q && !dn.ready && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a skid and a non-skid instance share stimulus and are
// compared every cycle against a queue-based model of the stage.
module tb_pipe_skid_stage;

    localparam int unsigned W   = 8;
    localparam logic [7:0]  BUB = 8'h80;
    localparam int unsigned CW  = 2;
    localparam int          CNT_MAX = 3;

    logic          sys_clk;
    logic          sys_rst;
    logic          flush;
    logic [1:0]    occ_s, occ_n;
    logic [CW-1:0] cnt_s, cnt_n;

    pipe_skid_stage_if #(.WIDTH(W)) up_s (), dn_s (), up_n (), dn_n ();

    pipe_skid_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1), .CNT_W(CW)) u_dut_s (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .flush     (flush),
        .up        (up_s),
        .dn        (dn_s),
        .occupancy (occ_s),
        .stall_cnt (cnt_s)
    );

    pipe_skid_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0), .CNT_W(CW)) u_dut_n (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .flush     (flush),
        .up        (up_n),
        .dn        (dn_n),
        .occupancy (occ_n),
        .stall_cnt (cnt_n)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Model: each stage is an ordered queue of live payloads plus a stall counter.
    logic [7:0] q_s[$];
    logic [7:0] q_n[$];
    int         mc_s = 0;
    int         mc_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input bit skid, input int sz, input bit ordy);
        if (skid) return sz < 2;
        return (sz == 0) || ordy;
    endfunction

    task automatic drive(input bit r, input bit f, input bit iv, input logic [7:0] d, input bit ordy);
        sys_rst    = r;
        flush      = f;
        up_s.valid = iv;
        up_n.valid = iv;
        up_s.data  = d;
        up_n.data  = d;
        dn_s.ready = ordy;
        dn_n.ready = ordy;
    endtask

    // One clock: drive, check mid-cycle against the model, clock, advance the model.
    task automatic cycle(input bit r, input bit f, input bit iv, input logic [7:0] d,
                         input bit ordy, input bit chk);
        bit rdy_s;
        bit rdy_n;
        drive(r, f, iv, d, ordy);
        #2;
        rdy_s = exp_ready(1'b1, q_s.size(), ordy);
        rdy_n = exp_ready(1'b0, q_n.size(), ordy);
        if (chk) begin
            check_eq("s.in_ready",  32'(up_s.ready), 32'(rdy_s));
            check_eq("s.out_valid", 32'(dn_s.valid), 32'(q_s.size() > 0));
            check_eq("s.out_data",  32'(dn_s.data),  32'((q_s.size() > 0) ? q_s[0] : BUB));
            check_eq("s.occupancy", 32'(occ_s),      32'(q_s.size()));
            check_eq("s.stall_cnt", 32'(cnt_s),      32'(mc_s));
            check_eq("n.in_ready",  32'(up_n.ready), 32'(rdy_n));
            check_eq("n.out_valid", 32'(dn_n.valid), 32'(q_n.size() > 0));
            check_eq("n.out_data",  32'(dn_n.data),  32'((q_n.size() > 0) ? q_n[0] : BUB));
            check_eq("n.occupancy", 32'(occ_n),      32'(q_n.size()));
            check_eq("n.stall_cnt", 32'(cnt_n),      32'(mc_n));
        end
        @(posedge sys_clk);
        #1;
        if (r) begin
            q_s.delete();
            q_n.delete();
            mc_s = 0;
            mc_n = 0;
        end else begin
            if (q_s.size() > 0 && !ordy && mc_s != CNT_MAX) mc_s++;
            if (q_n.size() > 0 && !ordy && mc_n != CNT_MAX) mc_n++;
            if (f) begin
                q_s.delete();
                q_n.delete();
            end else begin
                if (q_s.size() > 0 && ordy) void'(q_s.pop_front());
                if (iv && rdy_s) q_s.push_back(d);
                if (q_n.size() > 0 && ordy) void'(q_n.pop_front());
                if (iv && rdy_n) q_n.push_back(d);
            end
        end
    endtask

    initial begin
        // Reset held for two cycles; outputs are unknown before the first edge.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("rst.out_data", 32'(dn_s.data), 32'h80);
        check_eq("rst.in_ready", 32'(up_n.ready), 32'h1);

        // Streaming with no gaps.
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'(i), 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Skid fill then drain.
        cycle(1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1);
        check_eq("fill.occ", 32'(occ_s), 32'd2);
        check_eq("fill.in_ready", 32'(up_s.ready), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Flush in TWO together with a new payload.
        cycle(1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hB4, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
        check_eq("flush.out_valid", 32'(dn_s.valid), 32'd0);
        check_eq("flush.out_data", 32'(dn_s.data), 32'h80);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Pass-through backpressure on the non-skid stage.
        cycle(1'b0, 1'b0, 1'b1, 8'hD5, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hE6, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'hE6, 1'b1, 1'b1);
        check_eq("bp.out_data", 32'(dn_n.data), 32'hE6);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Counter saturation, then flush and reset behaviour.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("sat.cnt", 32'(cnt_s), 32'd3);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("sat.flush_cnt", 32'(cnt_s), 32'd3);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("sat.rst_cnt", 32'(cnt_n), 32'd0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 97) == 0, ($urandom % 19) == 0, ($urandom % 4) != 0,
                  8'($urandom), ($urandom % 3) != 0, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
